// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD 7-segment display scanner.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Non-decimal codes render as a dash so a bad digit is visible
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_DASH;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_disp_if.sv
// Digit data in, multiplexed segment/anode drive out.
// master drives the digits, slave is the scanner.
interface bcd_disp_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Pure combinational BCD digit to 7-segment decoder.
// Output is active-high; polarity is applied by the scanner.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    assign seg = bcd_to_seg(digit);
endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed, double-buffered 7-segment scanner with
// optional leading-zero blanking and a dead slot between digits.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    bcd_disp_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [4*NUM_DIGITS-1:0] active_bcd;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   active_dp;
    logic [3:0]              act_dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank;
    logic                    upper_zero;
    logic                    advance;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_seg;
    logic                    cur_blank;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    fd_r;

    assign advance = (cnt == CNT_LAST);
    assign wrap    = advance && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= advance ? '0 : cnt + 1'b1;
            if (advance)
                idx <= wrap ? '0 : idx + 1'b1;
        end
    end

    // Active only changes at frame wrap, so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            active_bcd <= '0;
            active_dp  <= '0;
        end else begin
            if (bus.load) begin
                shadow_bcd <= bus.bcd_in;
                shadow_dp  <= bus.dp_in;
            end
            if (wrap) begin
                active_bcd <= bus.load ? bus.bcd_in : shadow_bcd;
                active_dp  <= bus.load ? bus.dp_in  : shadow_dp;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            act_dig[i] = active_bcd[4*i +: 4];
    end

    // Blank a digit when it and every digit above it are zero
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (act_dig[i] == 4'd0);
            blank[i]   = bus.blank_lz && (i != 0) && upper_zero;
        end
    end

    assign cur_digit = act_dig[idx];
    assign cur_blank = blank[idx];

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= SEG_OFF;
            dp_r  <= 1'b0;
            an_r  <= '0;
            fd_r  <= 1'b0;
        end else begin
            seg_r <= cur_blank ? SEG_OFF : cur_seg;
            dp_r  <= !cur_blank && active_dp[idx];
            an_r  <= advance ? '0 : (AN_ONE << idx);
            fd_r  <= wrap;
        end
    end

    assign bus.seg        = ACTIVE_LOW_SEG ? ~seg_r : seg_r;
    assign bus.dp         = ACTIVE_LOW_SEG ? ~dp_r  : dp_r;
    assign bus.an         = ACTIVE_LOW_AN  ? ~an_r  : an_r;
    assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: 4 digits, 4-cycle slots, active-low.
// Reference model works from the absolute cycle count since reset.
module tb_bcd_display_scanner;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bcd_disp_if #(.NUM_DIGITS(4)) bus ();

    bcd_display_scanner #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] m_shadow;
    logic [15:0] m_active;
    logic [3:0]  m_sdp;
    logic [3:0]  m_adp;
    int          c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_sdp    = '0;
        m_adp    = '0;
        c        = 0;
    endtask

    // Called just after a rising edge; applies one cycle of inputs
    task automatic step(input logic ld, input logic [15:0] b,
                        input logic [3:0] d, input logic blz);
        int          dig_i;
        int          k;
        logic        bl;
        logic [3:0]  dig;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [3:0]  e_an;
        logic        e_fd;
        bus.load     = ld;
        bus.bcd_in   = b;
        bus.dp_in    = d;
        bus.blank_lz = blz;
        dig_i = (c / 4) % 4;
        k     = c % 4;
        dig   = 4'(m_active >> (4 * dig_i));
        bl    = blz && (dig_i != 0) && ((m_active >> (4 * dig_i)) == 16'h0);
        e_seg = bl ? 7'h7F : ~seg7(dig);
        e_dp  = bl ? 1'b1 : ~m_adp[dig_i];
        e_an  = (k == 3) ? 4'hF : ~(4'b0001 << dig_i);
        e_fd  = ((c % 16) == 15);
        @(posedge clk);
        #1;
        chk("seg", 16'(bus.seg), 16'(e_seg));
        chk("dp", 16'(bus.dp), 16'(e_dp));
        chk("an", 16'(bus.an), 16'(e_an));
        chk("frame_done", 16'(bus.frame_done), 16'(e_fd));
        if (ld) begin
            m_shadow = b;
            m_sdp    = d;
        end
        if ((c % 16) == 15) begin
            m_active = m_shadow;
            m_adp    = m_sdp;
        end
        c++;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            if ($urandom_range(1, 0) == 1)
                v[4*i +: 4] = 4'($urandom_range(15, 0));
        return v;
    endfunction

    initial begin
        int p1;
        int p2;
        logic blz;
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;
        model_reset();

        #2;
        chk("rst_seg", 16'(bus.seg), 16'h7F);
        chk("rst_dp", 16'(bus.dp), 16'h1);
        chk("rst_an", 16'(bus.an), 16'hF);
        chk("rst_fd", 16'(bus.frame_done), 16'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        step(1'b0, 16'h0, 4'h0, 1'b0);
        chk("first_an", 16'(bus.an), 16'hE);
        chk("first_seg", 16'(bus.seg), 16'h40);

        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h1234, 4'h0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0, 4'h0, 1'b0);

        step(1'b1, 16'h0050, 4'hF, 1'b1);
        for (int i = 0; i < 36; i++) step(1'b0, 16'h0, 4'h0, 1'b1);

        step(1'b1, 16'h000C, 4'h0, 1'b1);
        for (int i = 0; i < 36; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
        step(1'b1, 16'h0000, 4'h1, 1'b1);
        for (int i = 0; i < 36; i++) step(1'b0, 16'h0, 4'h0, 1'b1);

        for (int i = 0; i < 16 && (c % 16) != 15; i++)
            step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h9876, 4'h5, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 4'h0, 1'b0);

        p1 = -1;
        p2 = -100;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 16'h0, 4'h0, 1'b0);
            if (bus.frame_done === 1'b1) begin
                if (p1 < 0) p1 = i;
                else if (p2 < 0 || p2 == -100) p2 = i;
            end
        end
        chk("fd_period", 16'(p2 - p1), 16'd16);

        step(1'b1, 16'h4321, 4'hA, 1'b0);
        for (int i = 0; i < 32 && (c % 16) != 9; i++)
            step(1'b0, 16'h0, 4'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_seg", 16'(bus.seg), 16'h7F);
        chk("mid_rst_dp", 16'(bus.dp), 16'h1);
        chk("mid_rst_an", 16'(bus.an), 16'hF);
        chk("mid_rst_fd", 16'(bus.frame_done), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 24; i++) step(1'b0, 16'h0, 4'h0, 1'b0);

        blz = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((i % 50) == 0) blz = 1'($urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0)
                step(1'b1, rand_bcd(), 4'($urandom_range(15, 0)), blz);
            else
                step(1'b0, rand_bcd(), 4'($urandom_range(15, 0)), blz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
